// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use / RAW stall detection, redirect flush, and stall accounting.
// Define HAZARD_FORWARD_EN when the datapath forwards EX/MEM and MEM/WB results (only loads stall).
module hazard_ctrl (
   input  logic        clk,
   input  logic        reset,
   input  logic [4:0]  id_rs,
   input  logic [4:0]  id_rt,
   input  logic        id_uses_rt,
   input  logic        idex_memread,
   input  logic        idex_regwrite,
   input  logic [4:0]  idex_wreg,
   input  logic        exmem_regwrite,
   input  logic [4:0]  exmem_wreg,
   input  logic        ex_redirect,
   output logic        pc_write,
   output logic        ifid_write,
   output logic        ifid_flush,
   output logic        idex_flush,
   output logic [1:0]  state,
   output logic [15:0] stall_cnt
);

   typedef enum logic [1:0] {
      RUN     = 2'b00,
      STALL   = 2'b01,
      FLUSH   = 2'b10,
      ILLEGAL = 2'b11
   } state_e;

   state_e state_q;
   state_e state_d;

   logic match_idex;
   logic hazard_raw;
   logic hazard;
   logic stall;

   // Register 0 is hardwired to zero, so a write to it can never create a dependency.
   function automatic logic reg_match(input logic [4:0] dest,
                                      input logic [4:0] rs,
                                      input logic [4:0] rt,
                                      input logic       uses_rt);
      return (dest != 5'd0) && ((dest == rs) || (uses_rt && (dest == rt)));
   endfunction

   assign match_idex = reg_match(idex_wreg, id_rs, id_rt, id_uses_rt);

`ifdef HAZARD_FORWARD_EN
   // Everything except a load in EX can be forwarded, so only load-use pairs stall.
   logic unused_fwd_inputs;
   assign unused_fwd_inputs = ^{idex_regwrite, exmem_regwrite, exmem_wreg};
   assign hazard_raw = idex_memread & match_idex;
`else
   logic match_exmem;
   logic unused_nofwd_inputs;
   assign unused_nofwd_inputs = idex_memread;
   assign match_exmem = reg_match(exmem_wreg, id_rs, id_rt, id_uses_rt);
   assign hazard_raw  = (idex_regwrite & match_idex) | (exmem_regwrite & match_exmem);
`endif

   // IF/ID holds a NOP while in FLUSH, so its register fields are meaningless.
   assign hazard = hazard_raw & (state_q != FLUSH);
   assign stall  = hazard & ~ex_redirect;

   // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      state_d = RUN;
      if (state_q == ILLEGAL) begin
         state_d = RUN;
      end else if (ex_redirect) begin
         state_d = FLUSH;
      end else if (stall) begin
         state_d = STALL;
      end
   end

   // Reset forces the pipeline frozen with both stage registers bubbled, independent of clk.
   always_comb begin
      pc_write   = ~stall;
      ifid_write = ~stall;
      ifid_flush = ex_redirect;
      idex_flush = stall | ex_redirect;
      if (reset) begin
         pc_write   = 1'b0;
         ifid_write = 1'b0;
         ifid_flush = 1'b1;
         idex_flush = 1'b1;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= RUN;
         stall_cnt <= 16'd0;
      end else begin
         state_q <= state_d;
         if (stall && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
         end
      end
   end

   assign state = state_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: expectations are pushed when stimulus is driven and popped on output.
module tb_hazard_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic [4:0]  id_rs, id_rt, idex_wreg, exmem_wreg;
   logic        id_uses_rt, idex_memread, idex_regwrite, exmem_regwrite, ex_redirect;
   logic        pc_write, ifid_write, ifid_flush, idex_flush;
   logic [1:0]  state;
   logic [15:0] stall_cnt;

   int n_checks = 0;
   int n_errors = 0;

   typedef struct packed {
      logic        pc_write;
      logic        ifid_write;
      logic        ifid_flush;
      logic        idex_flush;
      logic [1:0]  state;
      logic [15:0] cnt;
   } exp_t;

   exp_t        sb[$];
   logic [1:0]  m_state;
   logic [15:0] m_cnt;
   logic [15:0] base_cnt;

   hazard_ctrl dut (
      .clk(clk), .reset(reset),
      .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
      .idex_memread(idex_memread), .idex_regwrite(idex_regwrite), .idex_wreg(idex_wreg),
      .exmem_regwrite(exmem_regwrite), .exmem_wreg(exmem_wreg),
      .ex_redirect(ex_redirect),
      .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
      .idex_flush(idex_flush), .state(state), .stall_cnt(stall_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      n_checks++;
      if (actual !== expected) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, actual, expected);
      end
   endtask

   function automatic logic m_match(input logic [4:0] d, input logic [4:0] rs,
                                    input logic [4:0] rt, input logic urt);
      return (d != 5'd0) && ((d == rs) || (urt && (d == rt)));
   endfunction

   task automatic step(input string tag, input logic [4:0] rs, input logic [4:0] rt, input logic urt,
                       input logic mr, input logic rw, input logic [4:0] wr,
                       input logic erw, input logic [4:0] ewr, input logic redir);
      logic h, s;
      exp_t e;
      id_rs = rs; id_rt = rt; id_uses_rt = urt;
      idex_memread = mr; idex_regwrite = rw; idex_wreg = wr;
      exmem_regwrite = erw; exmem_wreg = ewr; ex_redirect = redir;
`ifdef HAZARD_FORWARD_EN
      h = mr && m_match(wr, rs, rt, urt);
`else
      h = (rw && m_match(wr, rs, rt, urt)) || (erw && m_match(ewr, rs, rt, urt));
`endif
      if (m_state == 2'b10) h = 1'b0;
      s = h && !redir;
      e.pc_write   = !s;
      e.ifid_write = !s;
      e.ifid_flush = redir;
      e.idex_flush = s || redir;
      e.state      = (m_state == 2'b11) ? 2'b00 : redir ? 2'b10 : s ? 2'b01 : 2'b00;
      e.cnt        = (s && m_cnt != 16'hFFFF) ? m_cnt + 16'd1 : m_cnt;
      sb.push_back(e);
      @(negedge clk);
      check({tag, ".pc_write"},   pc_write,   sb[0].pc_write);
      check({tag, ".ifid_write"}, ifid_write, sb[0].ifid_write);
      check({tag, ".ifid_flush"}, ifid_flush, sb[0].ifid_flush);
      check({tag, ".idex_flush"}, idex_flush, sb[0].idex_flush);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      m_state = e.state;
      m_cnt   = e.cnt;
      check({tag, ".state"},     state,     e.state);
      check({tag, ".stall_cnt"}, stall_cnt, e.cnt);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1;
      id_rs = 5'd8; id_rt = 5'd0; id_uses_rt = 1'b0;
      idex_memread = 1'b1; idex_regwrite = 1'b1; idex_wreg = 5'd8;
      exmem_regwrite = 1'b0; exmem_wreg = 5'd0; ex_redirect = 1'b0;
      m_state = 2'b00; m_cnt = 16'd0;

      // Reset values, even with a hazard presented on the inputs.
      #12;
      check("rst.pc_write",   pc_write,   1'b0);
      check("rst.ifid_write", ifid_write, 1'b0);
      check("rst.ifid_flush", ifid_flush, 1'b1);
      check("rst.idex_flush", idex_flush, 1'b1);
      check("rst.state",      state,      2'b00);
      check("rst.stall_cnt",  stall_cnt,  16'd0);
      @(posedge clk); #1;
      reset = 1'b0;

      //    tag        rs  rt urt mr rw wr erw ewr redir
      step("idle",     0,  0, 0,  0, 0, 0, 0,  0,  0);
      step("reg0",     0,  0, 0,  1, 1, 0, 0,  0,  0);
      step("loaduse",  8,  0, 0,  1, 1, 8, 0,  0,  0);
      step("clear",    8,  0, 0,  0, 0, 0, 0,  0,  0);
      step("collide",  8,  0, 0,  1, 1, 8, 0,  0,  1);
      step("masked",   8,  0, 0,  1, 1, 8, 0,  0,  0);
      step("resume",   8,  0, 0,  1, 1, 8, 0,  0,  0);
      step("redir",    1,  2, 1,  0, 0, 0, 0,  0,  1);
      step("idle2",    0,  0, 0,  0, 0, 0, 0,  0,  0);
      step("nort",     0,  9, 0,  1, 1, 9, 1,  9,  0);
      step("exm_rs",   3,  0, 0,  0, 0, 0, 1,  3,  0);
      step("idle3",    0,  0, 0,  0, 0, 0, 0,  0,  0);

      // Two-cycle RAW dependency as the writer moves from ID/EX to EX/MEM.
      base_cnt = m_cnt;
      step("nf1",      0,  5, 1,  0, 1, 5, 0,  0,  0);
      step("nf2",      0,  5, 1,  0, 0, 0, 1,  5,  0);
      step("nf3",      0,  0, 0,  0, 0, 0, 0,  0,  0);
`ifndef HAZARD_FORWARD_EN
      check("nf.cnt_delta", stall_cnt, base_cnt + 16'd2);
`endif
      check("nf.run", state, 2'b00);

      // Asynchronous reset between edges while stalled.
      step("prestall", 8,  0, 0,  1, 1, 8, 0,  0,  0);
      #2;
      reset = 1'b1;
      #1;
      check("arst.pc_write",   pc_write,   1'b0);
      check("arst.ifid_write", ifid_write, 1'b0);
      check("arst.ifid_flush", ifid_flush, 1'b1);
      check("arst.idex_flush", idex_flush, 1'b1);
      check("arst.state",      state,      2'b00);
      check("arst.stall_cnt",  stall_cnt,  16'd0);
      @(posedge clk); #1;
      reset = 1'b0;
      m_state = 2'b00; m_cnt = 16'd0;

      // Saturation of the stall counter under a persistent hazard.
      for (int i = 0; i < 65540; i++) begin
         step("sat", 8, 0, 0, 1, 1, 8, 0, 0, 0);
      end
      check("sat.full", stall_cnt, 16'hFFFF);
      step("sat_hold", 8, 0, 0, 1, 1, 8, 0, 0, 0);
      step("sat_hold", 8, 0, 0, 1, 1, 8, 0, 0, 0);
      check("sat.stay", stall_cnt, 16'hFFFF);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, with ports as follows:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- id_rs  in  5  ID-stage source register rs (instr[25:21])
- id_rt  in  5  ID-stage source register rt (instr[20:16])
- id_uses_rt  in  1  ID instruction reads rt
- idex_memread  in  1  ID/EX stage holds a load
- idex_regwrite  in  1  ID/EX stage writes the register file
- idex_wreg  in  5  ID/EX destination register, after the RegDst mux
- exmem_regwrite  in  1  EX/MEM stage writes the register file
- exmem_wreg  in  5  EX/MEM destination register
- ex_redirect  in  1  branch taken or jump resolved in EX
- pc_write  out  1  PC load enable
- ifid_write  out  1  IF/ID load enable
- ifid_flush  out  1  IF/ID loads a NOP
- idex_flush  out  1  ID/EX loads zero WB/MEM/EX controls (bubble)
- state  out  2  registered FSM state
- stall_cnt  out  16  stall-cycle counter

Function
REQ-002 A match SHALL mean: dest != 0, and (dest == id_rs, or (id_uses_rt and dest == id_rt)).
REQ-003 The hazard condition SHALL be defined per REQ-017; register 0 SHALL never cause a hazard.
REQ-004 The hazard condition SHALL be masked (forced 0) while state == FLUSH, because IF/ID holds a NOP in that cycle.
REQ-005 stall SHALL equal hazard AND NOT ex_redirect, evaluated combinationally in the same cycle.
REQ-006 Output equations (combinational, zero latency):
- pc_write = ifid_write = NOT stall
- ifid_flush = ex_redirect
- idex_flush = stall OR ex_redirect
REQ-007 ex_redirect SHALL take priority over stall; on simultaneous redirect and hazard, the block SHALL flush both IF/ID and ID/EX and keep pc_write = 1.
REQ-008 The FSM SHALL have three states, encoded RUN = 2'b00, STALL = 2'b01, FLUSH = 2'b10; 2'b11 SHALL go to RUN on the next edge.
REQ-009 FSM next-state rules, in priority order, from any state:
- ex_redirect -> FLUSH
- else stall -> STALL
- else -> RUN
REQ-010 state SHALL be the registered next-state and SHALL reflect the previous cycle's decision.
REQ-011 stall_cnt SHALL increment by 1 on each rising edge where stall == 1, and SHALL saturate at 16'hFFFF without wrapping.
REQ-012 A stall SHALL last as long as the hazard persists; with forwarding this is exactly 1 cycle per load-use pair, and without forwarding it is at most 2 cycles.

Reset
REQ-013 While reset = 1, the block SHALL drive: state = RUN, stall_cnt = 0, pc_write = 0, ifid_write = 0, ifid_flush = 1, idex_flush = 1.
REQ-014 Reset asserted mid-stall or mid-flush SHALL take effect immediately, without waiting for clk.
REQ-015 After reset deasserts, the first edge SHALL evaluate from RUN.
REQ-016 No reset-release synchronization SHALL be done in this block.

Configuration
REQ-017 Macro HAZARD_FORWARD_EN SHALL select how the hazard condition is computed:
- Defined (datapath forwards EX/MEM and MEM/WB results): hazard = idex_memread AND match(idex_wreg); exmem_regwrite and exmem_wreg are ignored.
- Undefined (no forwarding): hazard = (idex_regwrite AND match(idex_wreg)) OR (exmem_regwrite AND match(exmem_wreg)).
- In both cases the register file writes in the first half-cycle, so the WB stage is never checked.

Verification
REQ-018 Load-use, HAZARD_FORWARD_EN defined:
- Stimulus: idex_memread = 1, idex_wreg = 8, id_rs = 8 for one cycle.
- Response: pc_write = 0, idex_flush = 1 for 1 cycle; state = STALL on the next edge; stall_cnt = 1.
REQ-019 Register-0 filter: idex_memread = 1, idex_wreg = 0, id_rs = 0 -> no stall, stall_cnt unchanged.
REQ-020 Redirect/hazard collision:
- Stimulus: ex_redirect = 1 in the same cycle as the REQ-018 hazard.
- Response: ifid_flush = 1, idex_flush = 1, pc_write = 1; state = FLUSH on the next edge.
- Next cycle: the same hazard inputs give no stall.
REQ-021 No forwarding (HAZARD_FORWARD_EN undefined):
- Stimulus: idex_regwrite = 1, idex_wreg = 5, id_rt = 5, id_uses_rt = 1; the next cycle moves the writer to exmem_wreg = 5.
- Response: 2 stall cycles, then RUN; stall_cnt = 2.
REQ-022 Saturation: hold a hazard for 70000 cycles -> stall_cnt = 16'hFFFF and stays there.
REQ-023 Async reset mid-stall: assert reset between clock edges -> state = RUN, stall_cnt = 0, and the REQ-013 output values appear before the next clk edge.
